// File: rtl/easyaxi_rd_chk.sv
// easyaxi_rd_chk: passive AXI read-channel checker (AR/R, master side).
// Tracks outstanding read bursts from AR handshakes and checks every R beat for
// data pattern (beat address), response code and RLAST placement. The first
// error latches a code, raises the sticky rd_resp_err and freezes all state
// until rst.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   enable                0 freezes all state
//   ar_valid/ready/addr/len   observed AR channel
//   r_valid/ready/data/resp/last  observed R channel
//   rd_resp_err           sticky error flag
//   err_code              first error: 1 data, 2 resp, 3 early last,
//                         4 missing last, 5 R with no burst, 6 AR overflow
//   burst_cnt             bursts completed without error (wraps)
//   ost_cnt               outstanding bursts in the FIFO
//   err_addr              (only with EASYAXI_RD_CHK_ERR_ADDR_EN) address of the
//                         first error
//
// Optional feature macro: EASYAXI_RD_CHK_ERR_ADDR_EN
module easyaxi_rd_chk #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned LEN_W     = 8,
    parameter int unsigned OST_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       ar_valid,
    input  logic                       ar_ready,
    input  logic [ADDR_W-1:0]          ar_addr,
    input  logic [LEN_W-1:0]           ar_len,
    input  logic                       r_valid,
    input  logic                       r_ready,
    input  logic [DATA_W-1:0]          r_data,
    input  logic [1:0]                 r_resp,
    input  logic                       r_last,
    output logic                       rd_resp_err,
    output logic [2:0]                 err_code,
    output logic [15:0]                burst_cnt,
`ifdef EASYAXI_RD_CHK_ERR_ADDR_EN
    output logic [ADDR_W-1:0]          err_addr,
`endif
    output logic [$clog2(OST_DEPTH):0] ost_cnt
);

    localparam int unsigned PTR_W   = $clog2(OST_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned BYTE_SH = $clog2(DATA_W / 8);

    typedef enum logic [0:0] {StChk, StErr} state_e;

    state_e             r_state, w_state_nxt;
    logic [ADDR_W-1:0]  r_fifo_addr [OST_DEPTH];
    logic [LEN_W-1:0]   r_fifo_len  [OST_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]   r_ost_cnt;
    logic [LEN_W-1:0]   r_beat;
    logic [15:0]        r_burst_cnt;
    logic [2:0]         r_err_code;

    logic               w_active, w_ar_hs, w_r_hs, w_r_chk, w_empty, w_full;
    logic [ADDR_W-1:0]  w_head_addr, w_exp_addr;
    logic [LEN_W-1:0]   w_head_len;
    logic [DATA_W-1:0]  w_exp_data;
    logic               w_last_idx, w_last_hs;
    logic               w_e1, w_e2, w_e3, w_e4, w_e5, w_e6;
    logic [2:0]         w_err_code;
    logic               w_any_err, w_push, w_pop, w_beat_upd;

    assign w_active    = enable && (r_state == StChk);
    assign w_ar_hs     = w_active && ar_valid && ar_ready;
    assign w_r_hs      = w_active && r_valid && r_ready;
    assign w_empty     = (r_ost_cnt == '0);
    assign w_full      = (r_ost_cnt == CNT_W'(OST_DEPTH));
    assign w_r_chk     = w_r_hs && !w_empty;

    assign w_head_addr = r_fifo_addr[r_rd_ptr];
    assign w_head_len  = r_fifo_len[r_rd_ptr];
    // Beat address wraps modulo 2^ADDR_W; data pattern is that address resized.
    assign w_exp_addr  = w_head_addr + (ADDR_W'(r_beat) << BYTE_SH);
    assign w_exp_data  = DATA_W'(w_exp_addr);
    assign w_last_idx  = (r_beat == w_head_len);
    assign w_last_hs   = w_r_chk && w_last_idx && r_last;

    assign w_e5 = w_r_hs && w_empty;
    assign w_e4 = w_r_chk && w_last_idx && !r_last;
    assign w_e3 = w_r_chk && !w_last_idx && r_last;
    assign w_e2 = w_r_chk && (r_resp != 2'b00);
    assign w_e1 = w_r_chk && (r_data != w_exp_data);
    // A full FIFO still accepts the push when the same cycle pops the head.
    assign w_e6 = w_ar_hs && w_full && !w_last_hs;

    always_comb begin
        w_err_code = 3'd0;
        if (w_e5)      w_err_code = 3'd5;
        else if (w_e4) w_err_code = 3'd4;
        else if (w_e3) w_err_code = 3'd3;
        else if (w_e2) w_err_code = 3'd2;
        else if (w_e1) w_err_code = 3'd1;
        else if (w_e6) w_err_code = 3'd6;
    end

    assign w_any_err  = (w_err_code != 3'd0);
    // An erroring cycle commits nothing: state freezes from the error onward.
    assign w_push     = w_ar_hs && !w_any_err;
    assign w_pop      = w_last_hs && !w_any_err;
    assign w_beat_upd = w_r_chk && !w_any_err;

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == StChk && w_any_err) begin
            w_state_nxt = StErr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= StChk;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= ar_addr;
            r_fifo_len[r_wr_ptr]  <= ar_len;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_ost_cnt   <= '0;
            r_beat      <= '0;
            r_burst_cnt <= '0;
            r_err_code  <= '0;
        end else begin
            if (w_any_err) r_err_code <= w_err_code;
            if (w_push)    r_wr_ptr   <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + 1'b1;
                r_burst_cnt <= r_burst_cnt + 16'd1;
            end
            if (w_beat_upd) r_beat <= w_pop ? '0 : r_beat + 1'b1;
            r_ost_cnt <= r_ost_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

`ifdef EASYAXI_RD_CHK_ERR_ADDR_EN
    logic [ADDR_W-1:0] r_err_addr, w_err_addr_nxt;

    always_comb begin
        w_err_addr_nxt = w_exp_addr;
        if (w_err_code == 3'd5)      w_err_addr_nxt = '0;
        else if (w_err_code == 3'd6) w_err_addr_nxt = ar_addr;
    end

    always_ff @(posedge clk) begin
        if (rst)            r_err_addr <= '0;
        else if (w_any_err) r_err_addr <= w_err_addr_nxt;
    end

    assign err_addr = r_err_addr;
`endif

    assign rd_resp_err = (r_state == StErr);
    assign err_code    = r_err_code;
    assign burst_cnt   = r_burst_cnt;
    assign ost_cnt     = r_ost_cnt;

endmodule

// File: tb/tb_easyaxi_rd_chk.sv
module tb_easyaxi_rd_chk;

    logic        clk = 1'b0;
    logic        rst, enable;
    logic        ar_valid, ar_ready;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic        r_valid, r_ready;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic        rd_resp_err;
    logic [2:0]  err_code;
    logic [15:0] burst_cnt;
    logic [2:0]  ost_cnt;
`ifdef EASYAXI_RD_CHK_ERR_ADDR_EN
    logic [31:0] err_addr;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    easyaxi_rd_chk dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .ar_valid    (ar_valid),
        .ar_ready    (ar_ready),
        .ar_addr     (ar_addr),
        .ar_len      (ar_len),
        .r_valid     (r_valid),
        .r_ready     (r_ready),
        .r_data      (r_data),
        .r_resp      (r_resp),
        .r_last      (r_last),
        .rd_resp_err (rd_resp_err),
        .err_code    (err_code),
        .burst_cnt   (burst_cnt),
`ifdef EASYAXI_RD_CHK_ERR_ADDR_EN
        .err_addr    (err_addr),
`endif
        .ost_cnt     (ost_cnt)
    );

    // Advance one clock; outputs are stable 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic err, input logic [2:0] code,
                           input logic [15:0] bursts, input logic [2:0] ost);
        chk({tag, ".err"},   32'(rd_resp_err), 32'(err));
        chk({tag, ".code"},  32'(err_code),    32'(code));
        chk({tag, ".burst"}, 32'(burst_cnt),   32'(bursts));
        chk({tag, ".ost"},   32'(ost_cnt),     32'(ost));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic ar(input logic [31:0] addr, input logic [7:0] len);
        ar_valid = 1'b1; ar_ready = 1'b1; ar_addr = addr; ar_len = len;
        cyc();
        ar_valid = 1'b0;
    endtask

    task automatic rb(input logic [31:0] data, input logic [1:0] resp, input logic last);
        r_valid = 1'b1; r_ready = 1'b1; r_data = data; r_resp = resp; r_last = last;
        cyc();
        r_valid = 1'b0; r_last = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1;
        ar_valid = 1'b0; ar_ready = 1'b0; ar_addr = '0; ar_len = '0;
        r_valid = 1'b0; r_ready = 1'b0; r_data = '0; r_resp = '0; r_last = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        chk_all("reset", 1'b0, 3'd0, 16'd0, 3'd0);

        // Clean 4-beat burst.
        ar(32'h100, 8'd3);
        chk("ar1.ost", 32'(ost_cnt), 32'd1);
        rb(32'h100, 2'b00, 1'b0);
        rb(32'h104, 2'b00, 1'b0);
        rb(32'h108, 2'b00, 1'b0);
        chk("mid.burst", 32'(burst_cnt), 32'd0);
        rb(32'h10C, 2'b00, 1'b1);
        chk_all("burst1", 1'b0, 3'd0, 16'd1, 3'd0);

        // Beat address wraps modulo 2^ADDR_W.
        ar(32'hFFFF_FFFC, 8'd1);
        rb(32'hFFFF_FFFC, 2'b00, 1'b0);
        rb(32'h0000_0000, 2'b00, 1'b1);
        chk_all("wrap", 1'b0, 3'd0, 16'd2, 3'd0);

        // Data mismatch on beat 2; later good burst must not count.
        do_reset();
        ar(32'h0, 8'd1);
        rb(32'h0, 2'b00, 1'b0);
        rb(32'hDEAD, 2'b00, 1'b1);
        chk_all("data_err", 1'b1, 3'd1, 16'd0, 3'd1);
        ar(32'h200, 8'd0);
        rb(32'h200, 2'b00, 1'b1);
        chk_all("frozen", 1'b1, 3'd1, 16'd0, 3'd1);

        // Early last -> 3.
        do_reset();
        chk_all("reset2", 1'b0, 3'd0, 16'd0, 3'd0);
        ar(32'h40, 8'd2);
        rb(32'h40, 2'b00, 1'b0);
        rb(32'h44, 2'b00, 1'b1);
        chk("early_last.code", 32'(err_code), 32'd3);

        // Missing last -> 4.
        do_reset();
        ar(32'h40, 8'd2);
        rb(32'h40, 2'b00, 1'b0);
        rb(32'h44, 2'b00, 1'b0);
        chk("pre_miss.err", 32'(rd_resp_err), 32'd0);
        rb(32'h48, 2'b00, 1'b0);
        chk("miss_last.code", 32'(err_code), 32'd4);

        // Bad resp together with bad data -> resp wins (2).
        do_reset();
        ar(32'h10, 8'd0);
        rb(32'hBAD, 2'b10, 1'b1);
        chk_all("resp_err", 1'b1, 3'd2, 16'd0, 3'd1);

        // R beat with nothing outstanding -> 5.
        do_reset();
        rb(32'h0, 2'b00, 1'b1);
        chk_all("empty_r", 1'b1, 3'd5, 16'd0, 3'd0);

        // Five ARs with depth 4 -> 6.
        do_reset();
        for (int i = 0; i < 4; i++) ar(32'h1000 * (i + 1), 8'd0);
        chk_all("full4", 1'b0, 3'd0, 16'd0, 3'd4);
        ar(32'h9000, 8'd0);
        chk_all("overflow", 1'b1, 3'd6, 16'd0, 3'd4);
`ifdef EASYAXI_RD_CHK_ERR_ADDR_EN
        chk("overflow.addr", err_addr, 32'h9000);
`endif

        // Full FIFO: last beat of head plus new AR in the same cycle.
        do_reset();
        ar(32'h1000, 8'd0);
        ar(32'h2000, 8'd1);
        ar(32'h3000, 8'd0);
        ar(32'h4000, 8'd0);
        ar_valid = 1'b1; ar_ready = 1'b1; ar_addr = 32'h5000; ar_len = 8'd0;
        rb(32'h1000, 2'b00, 1'b1);
        ar_valid = 1'b0;
        chk_all("push_pop", 1'b0, 3'd0, 16'd1, 3'd4);
        rb(32'h2000, 2'b00, 1'b0);
        rb(32'h2004, 2'b00, 1'b1);
        rb(32'h3000, 2'b00, 1'b1);
        rb(32'h4000, 2'b00, 1'b1);
        rb(32'h5000, 2'b00, 1'b1);
        chk_all("drain", 1'b0, 3'd0, 16'd5, 3'd0);

        // enable=0 mid-burst holds everything, including the beat counter.
        do_reset();
        ar(32'h300, 8'd3);
        rb(32'h300, 2'b00, 1'b0);
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ar_valid = 1'b1; ar_ready = 1'b1; ar_addr = 32'h700;
            rb(32'hFFFF_0000 + 32'(i), 2'(i), i[0]);
        end
        ar_valid = 1'b0;
        chk_all("disabled", 1'b0, 3'd0, 16'd0, 3'd1);
        enable = 1'b1;
        rb(32'h304, 2'b00, 1'b0);
        rb(32'h308, 2'b00, 1'b0);
        rb(32'h30C, 2'b00, 1'b1);
        chk_all("resumed", 1'b0, 3'd0, 16'd1, 3'd0);

        // rst mid-burst clears everything; a fresh burst then passes.
        ar(32'h500, 8'd1);
        rb(32'h500, 2'b00, 1'b0);
        do_reset();
        chk_all("mid_rst", 1'b0, 3'd0, 16'd0, 3'd0);
        ar(32'h600, 8'd1);
        rb(32'h600, 2'b00, 1'b0);
        rb(32'h604, 2'b00, 1'b1);
        chk_all("fresh", 1'b0, 3'd0, 16'd1, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
